snake_ctrl: RTL

//  Game sequencer for the snake position datapath. Paces moves with a tick prescaler.

---
 rtl/snake_pkg.sv | 32 +++
 rtl/snake_tick_gen.sv | 31 +++
 rtl/snake_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game controller: FSM states,
// direction codes, coordinate width and the default step size.
package snake_pkg;

    localparam int unsigned COORD_W = 5;
    localparam int unsigned NUM_SEG = 4;
    localparam logic [COORD_W-1:0] STEP_DEF = 5'd20;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_CHECK,
        ST_MOVE,
        ST_GROW,
        ST_DIE,
        ST_DEAD
    } state_t;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_UP    = 2'd3
    } dir_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Game-step prescaler: counts while enabled and pulses o_tick on the last
// count of each DIV-cycle period, then restarts from zero.
module snake_tick_gen #(
    parameter int unsigned DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clear,
    output logic o_tick
);

    localparam int unsigned CW = $clog2(DIV);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(DIV - 1));
    assign o_tick = i_en && w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear || o_tick) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/snake_ctrl.sv
// Snake game sequencer: paces moves, latches direction, detects wall/self/food
// hits and strobes the position datapath. Define SNAKE_CTRL_WRAP_EN for wrap-around.
module snake_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned        TICK_DIV = 25_000_000,
    parameter logic [COORD_W-1:0] STEP     = STEP_DEF,
    parameter int unsigned        MAX_SEG  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] btn_dir,
    input  logic [4:0] head_x,
    input  logic [4:0] head_y,
    input  logic [4:0] snake_x1,
    input  logic [4:0] snake_y1,
    input  logic [4:0] snake_x2,
    input  logic [4:0] snake_y2,
    input  logic [4:0] snake_x3,
    input  logic [4:0] snake_y3,
    input  logic [4:0] snake_x4,
    input  logic [4:0] snake_y4,
    input  logic [4:0] food_x,
    input  logic [4:0] food_y,
    output logic       enable,
    output logic       grow,
    output logic       die,
    output logic [1:0] dir,
    output logic       food_eaten,
    output logic [7:0] score
);

`ifdef SNAKE_CTRL_WRAP_EN
    localparam logic WALL_EN = 1'b0;
`else
    localparam logic WALL_EN = 1'b1;
`endif

    localparam logic [2:0] SEG_MAX = 3'(MAX_SEG);

    state_t     r_state;
    dir_t       r_dir;
    dir_t       r_pend_dir;
    logic       r_enable;
    logic       r_grow;
    logic       r_die;
    logic       r_food_eaten;
    logic [7:0] r_score;
    logic [2:0] r_seg_cnt;

    logic         w_tick;
    logic         w_btn_vld;
    dir_t         w_btn_dir;
    dir_t         w_ref_dir;
    logic         w_btn_rev;
    logic [COORD_W:0] w_sum_x;
    logic [COORD_W:0] w_sum_y;
    coord_t       w_next_x;
    coord_t       w_next_y;
    logic         w_wall;
    logic         w_self;
    logic         w_food;
    coord_t       w_seg_x [NUM_SEG];
    coord_t       w_seg_y [NUM_SEG];

    snake_tick_gen #(
        .DIV(TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .i_en   (r_state == ST_RUN),
        .i_clear(r_state != ST_RUN),
        .o_tick (w_tick)
    );

    // Reversal is judged against the direction that will be in effect next,
    // so a press during CHECK compares with the direction being committed.
    always_comb begin
        w_btn_vld = |btn_dir;
        w_btn_dir = DIR_RIGHT;
        if (btn_dir[0])      w_btn_dir = DIR_RIGHT;
        else if (btn_dir[1]) w_btn_dir = DIR_DOWN;
        else if (btn_dir[2]) w_btn_dir = DIR_LEFT;
        else if (btn_dir[3]) w_btn_dir = DIR_UP;
        w_ref_dir = (r_state == ST_CHECK) ? r_pend_dir : r_dir;
        w_btn_rev = ((w_btn_dir ^ w_ref_dir) == 2'b10);
    end

    always_comb begin
        w_sum_x = {1'b0, head_x};
        w_sum_y = {1'b0, head_y};
        case (r_pend_dir)
            DIR_RIGHT: w_sum_x = {1'b0, head_x} + {1'b0, STEP};
            DIR_LEFT:  w_sum_x = {1'b0, head_x} - {1'b0, STEP};
            DIR_UP:    w_sum_y = {1'b0, head_y} + {1'b0, STEP};
            DIR_DOWN:  w_sum_y = {1'b0, head_y} - {1'b0, STEP};
            default:   w_sum_x = {1'b0, head_x};
        endcase
    end

    assign w_next_x = w_sum_x[COORD_W-1:0];
    assign w_next_y = w_sum_y[COORD_W-1:0];
    assign w_wall   = WALL_EN && (w_sum_x[COORD_W] || w_sum_y[COORD_W]);
    assign w_food   = (w_next_x == food_x) && (w_next_y == food_y);

    assign w_seg_x = '{snake_x1, snake_x2, snake_x3, snake_x4};
    assign w_seg_y = '{snake_y1, snake_y2, snake_y3, snake_y4};

    always_comb begin
        w_self = 1'b0;
        for (int unsigned n = 0; n < NUM_SEG; n++) begin
            if ((3'(n) < r_seg_cnt) && (w_seg_x[n] == w_next_x) && (w_seg_y[n] == w_next_y)) begin
                w_self = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_dir        <= DIR_RIGHT;
            r_pend_dir   <= DIR_RIGHT;
            r_enable     <= 1'b0;
            r_grow       <= 1'b0;
            r_die        <= 1'b0;
            r_food_eaten <= 1'b0;
            r_score      <= '0;
            r_seg_cnt    <= '0;
        end else begin
            r_enable     <= 1'b0;
            r_grow       <= 1'b0;
            r_food_eaten <= 1'b0;

            if ((r_state != ST_DEAD) && w_btn_vld && !w_btn_rev) begin
                r_pend_dir <= w_btn_dir;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_tick) r_state <= ST_CHECK;
                end
                ST_CHECK: begin
                    r_dir    <= r_pend_dir;
                    r_enable <= 1'b1;
                    if (w_wall || w_self) begin
                        r_state <= ST_DIE;
                        r_die   <= 1'b1;
                    end else if (w_food) begin
                        r_state      <= ST_GROW;
                        r_grow       <= (r_seg_cnt < SEG_MAX);
                        r_food_eaten <= 1'b1;
                        r_score      <= sat_inc8(r_score);
                        if (r_seg_cnt < SEG_MAX) r_seg_cnt <= r_seg_cnt + 3'd1;
                    end else begin
                        r_state <= ST_MOVE;
                    end
                end
                ST_GROW: begin
                    r_state  <= ST_MOVE;
                    r_enable <= 1'b1;
                end
                ST_MOVE: r_state <= ST_RUN;
                ST_DIE:  r_state <= ST_DEAD;
                ST_DEAD: r_state <= ST_DEAD;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign enable     = r_enable;
    assign grow       = r_grow;
    assign die        = r_die;
    assign dir        = r_dir;
    assign food_eaten = r_food_eaten;
    assign score      = r_score;

endmodule
